// File: rtl/beta_write_decode_pkg.sv
// ---------------------------------------------------------------------------
// beta_write_decode_pkg
// Shared memory-map definitions for the Beta bus decoders (write and read
// side). Holds the region codes, where the region field and the word index
// sit inside a Beta byte address, and the posted-write entry width.
// No ports (package).
// ---------------------------------------------------------------------------
package beta_write_decode_pkg;

    typedef enum logic [1:0] {
        REGION_RAM       = 2'd0,
        REGION_IO        = 2'd1,
        REGION_SHARED_RD = 2'd2,
        REGION_SHARED_WR = 2'd3
    } region_t;

    localparam int REGION_MSB  = 15;
    localparam int REGION_LSB  = 14;
    localparam int WORD_ADDR_W = 12;
    localparam int WORD_LSB    = 2;
    localparam int WORD_MSB    = WORD_LSB + WORD_ADDR_W - 1;
    localparam int DATA_W      = 32;
    localparam int SW_ENTRY_W  = WORD_ADDR_W + DATA_W;

    // Word index of a Beta byte address; the upper half and the byte
    // offset are not part of the memory map.
    function automatic logic [WORD_ADDR_W-1:0] wordIndex(input logic [31:0] addr);
        return addr[WORD_MSB:WORD_LSB];
    endfunction

endpackage

// File: rtl/beta_write_decode_if.sv
// ---------------------------------------------------------------------------
// beta_write_decode_if
// Bundles the Beta access signals and the three write ports of the write
// decoder.
//   master : the Beta/system side (drives address, data, strobes, grant)
//   slave  : the decoder (drives read_select, stall, RAM/IO/shared ports,
//            and the read-only-write error flag)
// ---------------------------------------------------------------------------
interface beta_write_decode_if
    import beta_write_decode_pkg::*;
();

    logic [31:0]            beta_ma;
    logic [DATA_W-1:0]      beta_mdout;
    logic                   beta_mwe;
    logic                   beta_moe;
    logic [2:0]             read_select;
    logic                   beta_stall;
    logic                   ram_we;
    logic [WORD_ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0]      ram_din;
    logic                   io_we;
    logic [WORD_ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0]      io_din;
    logic                   shared_req;
    logic                   shared_grant;
    logic                   shared_we;
    logic [WORD_ADDR_W-1:0] shared_addr;
    logic [DATA_W-1:0]      shared_din;
    logic                   err_ro_write;

    modport master (
        output beta_ma, beta_mdout, beta_mwe, beta_moe, shared_grant,
        input  read_select, beta_stall, ram_we, ram_addr, ram_din,
               io_we, io_addr, io_din, shared_req, shared_we,
               shared_addr, shared_din, err_ro_write
    );

    modport slave (
        input  beta_ma, beta_mdout, beta_mwe, beta_moe, shared_grant,
        output read_select, beta_stall, ram_we, ram_addr, ram_din,
               io_we, io_addr, io_din, shared_req, shared_we,
               shared_addr, shared_din, err_ro_write
    );

endinterface

// File: rtl/beta_write_decode_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO used as the posted-write buffer for the shared-write
// region.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write request and entry (ignored while full)
//   i_pop          : read request (ignored while empty)
//   o_data         : current head entry
//   o_empty/o_full : occupancy status before the next edge
// DEPTH must be a power of two so the pointers wrap on natural overflow.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    // Full/empty are judged on the occupancy before the edge, so a push
    // into a full FIFO is refused even when a pop happens alongside it.
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_data   = r_mem[r_rdPtr];

    // Pointers and occupancy; a simultaneous push and pop leaves the
    // count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

endmodule

// File: rtl/beta_write_decode.sv
// ---------------------------------------------------------------------------
// beta_write_decode
// Write-side address decoder for the Beta bus.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : beta_write_decode_if.slave carrying the Beta access
//                (beta_ma, beta_mdout, beta_mwe, beta_moe), read_select,
//                beta_stall, registered RAM and IO write ports, the
//                arbitrated shared-write port (shared_req/grant/we/addr/din)
//                and the sticky err_ro_write flag.
// RAM and IO writes are registered single-cycle pulses. Shared-region writes
// are posted into a FIFO and drained whenever the arbiter grants; reads of
// the shared-write region stall until the FIFO is empty so that they never
// overtake a pending write.
// ---------------------------------------------------------------------------
module beta_write_decode
    import beta_write_decode_pkg::*;
#(
    parameter int SW_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    beta_write_decode_if.slave  bus
);

    region_t                w_region;
    logic [WORD_ADDR_W-1:0] w_index;
    logic                   w_fifoEmpty;
    logic                   w_fifoFull;
    logic [SW_ENTRY_W-1:0]  w_head;
    logic                   w_isSharedWr;
    logic                   w_stall;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ramWrite;
    logic                   w_ioWrite;
    logic                   w_roWrite;
    logic                   w_unused_ma;

    logic                   r_ramWe;
    logic [WORD_ADDR_W-1:0] r_ramAddr;
    logic [DATA_W-1:0]      r_ramDin;
    logic                   r_ioWe;
    logic [WORD_ADDR_W-1:0] r_ioAddr;
    logic [DATA_W-1:0]      r_ioDin;
    logic                   r_errRoWrite;

    assign w_region    = region_t'(bus.beta_ma[REGION_MSB:REGION_LSB]);
    assign w_index     = wordIndex(bus.beta_ma);
    assign w_unused_ma = ^{bus.beta_ma[31:16], bus.beta_ma[1:0]};

    // A write stalls only when the buffer is full; a read of the same
    // region stalls while anything is still pending in the buffer.
    assign w_isSharedWr = (w_region == REGION_SHARED_WR);
    assign w_stall      = (bus.beta_mwe && w_isSharedWr && w_fifoFull) ||
                          (bus.beta_moe && w_isSharedWr && !w_fifoEmpty);

    assign w_push     = bus.beta_mwe && w_isSharedWr && !w_fifoFull && !w_stall;
    assign w_pop      = bus.shared_grant && !w_fifoEmpty;
    assign w_ramWrite = bus.beta_mwe && (w_region == REGION_RAM) && !w_stall;
    assign w_ioWrite  = bus.beta_mwe && (w_region == REGION_IO) && !w_stall;
    assign w_roWrite  = bus.beta_mwe && (w_region == REGION_SHARED_RD);

    assign bus.read_select = {1'b0, w_region};
    assign bus.beta_stall  = w_stall;
    assign bus.shared_req  = !w_fifoEmpty;
    assign bus.shared_we   = w_pop;
    assign bus.shared_addr = w_head[SW_ENTRY_W-1:DATA_W];
    assign bus.shared_din  = w_head[DATA_W-1:0];
    assign bus.ram_we      = r_ramWe;
    assign bus.ram_addr    = r_ramAddr;
    assign bus.ram_din     = r_ramDin;
    assign bus.io_we       = r_ioWe;
    assign bus.io_addr     = r_ioAddr;
    assign bus.io_din      = r_ioDin;
    assign bus.err_ro_write = r_errRoWrite;

    sync_fifo #(
        .WIDTH (SW_ENTRY_W),
        .DEPTH (SW_DEPTH)
    ) u_postedWrites (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({w_index, bus.beta_mdout}),
        .o_data  (w_head),
        .o_empty (w_fifoEmpty),
        .o_full  (w_fifoFull)
    );

    // Registered RAM/IO write ports: the strobe is a one-cycle pulse while
    // address and data hold the last accepted write. The read-only error
    // flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ramWe      <= 1'b0;
            r_ramAddr    <= '0;
            r_ramDin     <= '0;
            r_ioWe       <= 1'b0;
            r_ioAddr     <= '0;
            r_ioDin      <= '0;
            r_errRoWrite <= 1'b0;
        end else begin
            r_ramWe <= w_ramWrite;
            r_ioWe  <= w_ioWrite;
            if (w_ramWrite) begin
                r_ramAddr <= w_index;
                r_ramDin  <= bus.beta_mdout;
            end
            if (w_ioWrite) begin
                r_ioAddr <= w_index;
                r_ioDin  <= bus.beta_mdout;
            end
            if (w_roWrite) begin
                r_errRoWrite <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_beta_write_decode.sv
// ---------------------------------------------------------------------------
// tb_beta_write_decode
// Self-checking bench for beta_write_decode: directed scenarios for the
// memory-map behaviours plus a randomized run against a queue-based model.
// ---------------------------------------------------------------------------
module tb_beta_write_decode;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    beta_write_decode_if bus ();

    beta_write_decode #(.SW_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one Beta access plus the arbiter grant.
    task automatic drive(input logic [31:0] ma, input logic [31:0] dout,
                         input logic mwe, input logic moe, input logic grant);
        bus.beta_ma      = ma;
        bus.beta_mdout   = dout;
        bus.beta_mwe     = mwe;
        bus.beta_moe     = moe;
        bus.shared_grant = grant;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_we: got %b expected 0", bus.ram_we); end
        checks++; if (bus.io_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_io_we: got %b expected 0", bus.io_we); end
        checks++; if ({bus.ram_addr, bus.ram_din} !== 44'h0) begin errors++; $display("[TB] FAIL reset_ram_port: got %h/%h expected 0/0", bus.ram_addr, bus.ram_din); end
        checks++; if ({bus.io_addr, bus.io_din} !== 44'h0) begin errors++; $display("[TB] FAIL reset_io_port: got %h/%h expected 0/0", bus.io_addr, bus.io_din); end
        checks++; if (bus.shared_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_shared_req: got %b expected 0", bus.shared_req); end
        checks++; if (bus.err_ro_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err_ro_write); end
        checks++; if (bus.beta_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.beta_stall); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ram_write();
        drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.read_select !== 3'd0) begin errors++; $display("[TB] FAIL ram_read_select: got %0d expected 0", bus.read_select); end
        tick();
        checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("[TB] FAIL ram_we_pulse: got %b expected 1", bus.ram_we); end
        checks++; if (bus.ram_addr !== 12'h004) begin errors++; $display("[TB] FAIL ram_addr: got %h expected 004", bus.ram_addr); end
        checks++; if (bus.ram_din !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_din: got %h expected deadbeef", bus.ram_din); end
        checks++; if (bus.io_we !== 1'b0) begin errors++; $display("[TB] FAIL ram_no_io_we: got %b expected 0", bus.io_we); end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL ram_we_one_cycle: got %b expected 0", bus.ram_we); end
        checks++; if (bus.ram_addr !== 12'h004) begin errors++; $display("[TB] FAIL ram_addr_hold: got %h expected 004", bus.ram_addr); end
    endtask

    task automatic test_io_write();
        logic [11:0] idx;
        logic [31:0] data;
        for (int n = 0; n < 4; n++) begin
            idx  = 12'($urandom);
            data = $urandom;
            drive({16'($urandom), 2'b01, idx, 2'($urandom)}, data, 1'b1, 1'b0, 1'b0);
            tick();
            checks++; if ({bus.io_we, bus.io_addr, bus.io_din} !== {1'b1, idx, data}) begin errors++; $display("[TB] FAIL io_write: got %b/%h/%h expected 1/%h/%h", bus.io_we, bus.io_addr, bus.io_din, idx, data); end
            checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL io_no_ram_we: got %b expected 0", bus.ram_we); end
            drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            tick();
            checks++; if (bus.io_we !== 1'b0) begin errors++; $display("[TB] FAIL io_we_one_cycle: got %b expected 0", bus.io_we); end
        end
    endtask

    task automatic test_ro_write();
        drive(32'h0000_8000, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.beta_stall !== 1'b0) begin errors++; $display("[TB] FAIL ro_stall: got %b expected 0", bus.beta_stall); end
        checks++; if (bus.read_select !== 3'd2) begin errors++; $display("[TB] FAIL ro_read_select: got %0d expected 2", bus.read_select); end
        tick();
        checks++; if (bus.err_ro_write !== 1'b1) begin errors++; $display("[TB] FAIL ro_err_set: got %b expected 1", bus.err_ro_write); end
        checks++; if ({bus.ram_we, bus.io_we, bus.shared_req} !== 3'b000) begin errors++; $display("[TB] FAIL ro_no_write: got %b expected 000", {bus.ram_we, bus.io_we, bus.shared_req}); end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) tick();
        checks++; if (bus.err_ro_write !== 1'b1) begin errors++; $display("[TB] FAIL ro_err_sticky: got %b expected 1", bus.err_ro_write); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.err_ro_write !== 1'b0) begin errors++; $display("[TB] FAIL ro_err_cleared: got %b expected 0", bus.err_ro_write); end
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fifo_full();
        logic [31:0] data [5];
        for (int i = 0; i < 5; i++) data[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            drive(32'h0000_C000 + 32'(4 * i), data[i], 1'b1, 1'b0, 1'b0);
            #1;
            checks++; if (bus.beta_stall !== 1'b0) begin errors++; $display("[TB] FAIL full_accept_stall%0d: got %b expected 0", i, bus.beta_stall); end
            tick();
        end
        drive(32'h0000_C010, data[4], 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.beta_stall !== 1'b1) begin errors++; $display("[TB] FAIL full_fifth_stall: got %b expected 1", bus.beta_stall); end
        tick();
        checks++; if ({bus.shared_req, bus.shared_we, bus.shared_addr} !== {2'b10, 12'h000}) begin errors++; $display("[TB] FAIL full_hold_head: got %b/%b/%h expected 1/0/000", bus.shared_req, bus.shared_we, bus.shared_addr); end
        bus.shared_grant = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if ({bus.shared_we, bus.shared_addr, bus.shared_din} !== {1'b1, 12'(k), data[k]}) begin errors++; $display("[TB] FAIL full_drain%0d: got %b/%h/%h expected 1/%h/%h", k, bus.shared_we, bus.shared_addr, bus.shared_din, 12'(k), data[k]); end
            if (k < 2) begin
                checks++; if (bus.beta_stall !== (k == 0)) begin errors++; $display("[TB] FAIL full_stall_release%0d: got %b expected %b", k, bus.beta_stall, (k == 0)); end
            end
            tick();
            if (k == 1) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        #1;
        checks++; if ({bus.shared_req, bus.shared_we} !== 2'b00) begin errors++; $display("[TB] FAIL full_drained: got %b expected 00", {bus.shared_req, bus.shared_we}); end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_simul_push_pop();
        for (int i = 0; i < 2; i++) begin
            drive(32'h0000_C040 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(32'h0000_C048, 32'hA000_0002, 1'b1, 1'b0, 1'b1);
        #1;
        checks++; if ({bus.shared_we, bus.shared_addr, bus.beta_stall} !== {1'b1, 12'h010, 1'b0}) begin errors++; $display("[TB] FAIL pp_oldest_popped: got %b/%h/%b expected 1/010/0", bus.shared_we, bus.shared_addr, bus.beta_stall); end
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if ({bus.shared_we, bus.shared_addr, bus.shared_din} !== {1'b1, 12'h011 + 12'(k), 32'hA000_0001 + 32'(k)}) begin errors++; $display("[TB] FAIL pp_drain%0d: got %b/%h/%h expected 1/%h/%h", k, bus.shared_we, bus.shared_addr, bus.shared_din, 12'h011 + 12'(k), 32'hA000_0001 + 32'(k)); end
            tick();
        end
        checks++; if (bus.shared_req !== 1'b0) begin errors++; $display("[TB] FAIL pp_occupancy_two: got req %b expected 0", bus.shared_req); end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_read_hazard();
        drive(32'h0000_C000, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h0000_C000, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if ({bus.beta_stall, bus.read_select} !== {1'b1, 3'd3}) begin errors++; $display("[TB] FAIL raw_stall%0d: got %b/%0d expected 1/3", n, bus.beta_stall, bus.read_select); end
            tick();
        end
        bus.shared_grant = 1'b1;
        #1;
        checks++; if ({bus.beta_stall, bus.shared_we} !== 2'b11) begin errors++; $display("[TB] FAIL raw_drain: got %b expected 11", {bus.beta_stall, bus.shared_we}); end
        tick();
        checks++; if ({bus.beta_stall, bus.read_select} !== {1'b0, 3'd3}) begin errors++; $display("[TB] FAIL raw_release: got %b/%0d expected 0/3", bus.beta_stall, bus.read_select); end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_C100 + 32'(4 * i), $urandom, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.shared_req !== 1'b1) begin errors++; $display("[TB] FAIL rm_pending: got %b expected 1", bus.shared_req); end
        bus.shared_grant = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.shared_req, bus.shared_we} !== 2'b00) begin errors++; $display("[TB] FAIL rm_async_drop: got %b expected 00", {bus.shared_req, bus.shared_we}); end
        #2;
        rst_n = 1'b1;
        tick();
        checks++; if ({bus.shared_req, bus.shared_we} !== 2'b00) begin errors++; $display("[TB] FAIL rm_no_we_after: got %b expected 00", {bus.shared_req, bus.shared_we}); end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    // Randomized run: the model keeps the posted writes as a queue of
    // {index, data} and derives every output from the memory-map rules.
    task automatic test_random();
        logic [43:0] q [$];
        logic [1:0]  region;
        logic [11:0] idx;
        logic [31:0] ma, data;
        logic        mwe, moe, grant, expStall, expRamWe, expIoWe, expErr;
        logic [11:0] expRamAddr, expIoAddr;
        logic [31:0] expRamDin, expIoDin;
        int          r;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        pulseReset();
        tick();
        expRamAddr = '0; expRamDin = '0; expIoAddr = '0; expIoDin = '0; expErr = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r      = $urandom_range(0, 6);
            region = (r > 3) ? 2'd3 : 2'(r);
            idx    = 12'($urandom);
            data   = $urandom;
            ma     = {16'($urandom), region, idx, 2'($urandom)};
            mwe    = ($urandom_range(0, 3) != 0);
            moe    = ($urandom_range(0, 3) == 0);
            grant  = ($urandom_range(0, 2) == 0);
            drive(ma, data, mwe, moe, grant);
            #1;
            expStall = (region == 2'd3) && ((mwe && q.size() == DEPTH) || (moe && q.size() != 0));
            checks++; if ({bus.beta_stall, bus.read_select} !== {expStall, 1'b0, region}) begin errors++; $display("[TB] FAIL rnd_comb%0d: got %b/%0d expected %b/%0d", n, bus.beta_stall, bus.read_select, expStall, region); end
            checks++; if ({bus.shared_req, bus.shared_we} !== {q.size() != 0, grant && q.size() != 0}) begin errors++; $display("[TB] FAIL rnd_req%0d: got %b/%b expected %b/%b", n, bus.shared_req, bus.shared_we, q.size() != 0, grant && q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if ({bus.shared_addr, bus.shared_din} !== q[0]) begin errors++; $display("[TB] FAIL rnd_head%0d: got %h/%h expected %h", n, bus.shared_addr, bus.shared_din, q[0]); end
            end
            tick();
            if (grant && q.size() != 0) void'(q.pop_front());
            if (mwe && region == 2'd3 && !expStall) q.push_back({idx, data});
            expRamWe = mwe && region == 2'd0;
            expIoWe  = mwe && region == 2'd1;
            if (expRamWe) begin expRamAddr = idx; expRamDin = data; end
            if (expIoWe) begin expIoAddr = idx; expIoDin = data; end
            if (mwe && region == 2'd2) expErr = 1'b1;
            checks++; if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== {expRamWe, expRamAddr, expRamDin}) begin errors++; $display("[TB] FAIL rnd_ram%0d: got %b/%h/%h expected %b/%h/%h", n, bus.ram_we, bus.ram_addr, bus.ram_din, expRamWe, expRamAddr, expRamDin); end
            checks++; if ({bus.io_we, bus.io_addr, bus.io_din} !== {expIoWe, expIoAddr, expIoDin}) begin errors++; $display("[TB] FAIL rnd_io%0d: got %b/%h/%h expected %b/%h/%h", n, bus.io_we, bus.io_addr, bus.io_din, expIoWe, expIoAddr, expIoDin); end
            checks++; if (bus.err_ro_write !== expErr) begin errors++; $display("[TB] FAIL rnd_err%0d: got %b expected %b", n, bus.err_ro_write, expErr); end
        end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Hard bound on the whole run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        test_reset();
        test_ram_write();
        test_io_write();
        test_ro_write();
        test_fifo_full();
        test_simul_push_pop();
        test_read_hazard();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
